// File: rtl/tsched_pkg.sv
// rtl/tsched_pkg.sv - shared state codes, player-count encodings and decode helper
package tsched_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_PICK = 3'd1,
        S_MOVE      = 3'd2,
        S_CHECK     = 3'd3,
        S_NEXT      = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    localparam logic [1:0] NP_ENC_2   = 2'b00;
    localparam logic [1:0] NP_ENC_3   = 2'b01;
    localparam logic [1:0] NP_ENC_4   = 2'b10;
    localparam logic [1:0] NP_ENC_4_R = 2'b11;

    localparam logic [2:0] NPLAYERS_RESET = 3'd2;

    // The reserved encoding plays as a four-player game.
    function automatic logic [2:0] nplayers_decode(input logic [1:0] enc);
        case (enc)
            NP_ENC_2:   nplayers_decode = 3'd2;
            NP_ENC_3:   nplayers_decode = 3'd3;
            NP_ENC_4:   nplayers_decode = 3'd4;
            NP_ENC_4_R: nplayers_decode = 3'd4;
            default:    nplayers_decode = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-pick saturating timer with terminal-count flag
module turn_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TIMEOUT_W      = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [TIMEOUT_W-1:0] TERM_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    // Clear wins over enable; the count sticks at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == TERM_COUNT);

endmodule

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - game-flow FSM sequencing turns among 2-4 players
module turn_scheduler
    import tsched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TIMEOUT_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] num_players,
    input  logic       pick_valid,
    input  logic       pick_match,
    input  logic       move_done,
    input  logic       win_in,
    output logic [1:0] cur_player,
    output logic       move_req,
    output logic       turn_done,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    state_t     state_q,      state_d;
    logic [1:0] cur_player_q, cur_player_d;
    logic [2:0] nplayers_q,   nplayers_d;
    logic [1:0] winner_q,     winner_d;
    logic       move_req_q,   move_req_d;
    logic       turn_done_q,  turn_done_d;
    logic       game_over_q,  game_over_d;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_terminal;
    logic       last_player;

    assign last_player  = ({1'b0, cur_player_q} == (nplayers_q - 3'd1));
    assign timer_enable = (state_q == S_WAIT_PICK) && !abort;

    turn_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_turn_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .terminal (timer_terminal)
    );

    // Next-state and output decode; pulse outputs are set on the transition so they appear registered.
    always_comb begin
        state_d      = state_q;
        cur_player_d = cur_player_q;
        nplayers_d   = nplayers_q;
        winner_d     = winner_q;
        move_req_d   = 1'b0;
        turn_done_d  = 1'b0;
        timer_clear  = 1'b0;
        if (abort) begin
            state_d      = S_IDLE;
            cur_player_d = 2'd0;
            timer_clear  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        nplayers_d   = nplayers_decode(num_players);
                        cur_player_d = 2'd0;
                        timer_clear  = 1'b1;
                        state_d      = S_WAIT_PICK;
                    end
                end
                S_WAIT_PICK: begin
                    // A pick landing on the terminal cycle is still a pick.
                    if (pick_valid) begin
                        if (pick_match) begin
                            move_req_d = 1'b1;
                            state_d    = S_MOVE;
                        end else begin
                            turn_done_d = 1'b1;
                            state_d     = S_NEXT;
                        end
                    end else if (timer_terminal) begin
                        turn_done_d = 1'b1;
                        state_d     = S_NEXT;
                    end
                end
                S_MOVE: begin
                    if (move_done) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (win_in) begin
                        winner_d = cur_player_q;
                        state_d  = S_OVER;
                    end else begin
                        timer_clear = 1'b1;
                        state_d     = S_WAIT_PICK;
                    end
                end
                S_NEXT: begin
                    cur_player_d = last_player ? 2'd0 : (cur_player_q + 2'd1);
                    timer_clear  = 1'b1;
                    state_d      = S_WAIT_PICK;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        game_over_d = (state_d == S_OVER);
    end

    // FSM, turn register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_player_q <= 2'd0;
            nplayers_q   <= NPLAYERS_RESET;
            winner_q     <= 2'd0;
            move_req_q   <= 1'b0;
            turn_done_q  <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_player_q <= cur_player_d;
            nplayers_q   <= nplayers_d;
            winner_q     <= winner_d;
            move_req_q   <= move_req_d;
            turn_done_q  <= turn_done_d;
            game_over_q  <= game_over_d;
        end
    end

    assign cur_player = cur_player_q;
    assign move_req   = move_req_q;
    assign turn_done  = turn_done_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - scoreboard bench for turn_scheduler
module tb_turn_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] num_players;
    logic       pick_valid;
    logic       pick_match;
    logic       move_done;
    logic       win_in;
    logic [1:0] cur_player;
    logic       move_req;
    logic       turn_done;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_o;

    typedef struct packed {
        logic       is_move;
        logic [1:0] player;
    } evt_t;

    evt_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    turn_scheduler #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_W      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_players (num_players),
        .pick_valid  (pick_valid),
        .pick_match  (pick_match),
        .move_done   (move_done),
        .win_in      (win_in),
        .cur_player  (cur_player),
        .move_req    (move_req),
        .turn_done   (turn_done),
        .game_over   (game_over),
        .winner      (winner),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input logic is_move, input logic [1:0] player);
        evt_t e;
        e.is_move = is_move;
        e.player  = player;
        exp_q.push_back(e);
    endtask

    // Miss pick: NEXT for one cycle, then the turn advances.
    task automatic do_miss(input logic [1:0] player, input logic [1:0] next_player);
        expect_evt(1'b0, player);
        pick_valid = 1'b1;
        pick_match = 1'b0;
        step();
        pick_valid = 1'b0;
        step();
        chk("miss_next_player", int'(cur_player), int'(next_player));
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (move_req === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mon_move_unexpected: move_req=1 player=%0d, expected no event", cur_player);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_move || e.player != cur_player) begin
                            errors++;
                            $display("FAIL mon_move: got move player=%0d expected is_move=%0d player=%0d",
                                     cur_player, e.is_move, e.player);
                        end
                    end
                end
                if (turn_done === 1'b1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL mon_turn_unexpected: turn_done=1 player=%0d, expected no event", cur_player);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_move || e.player != cur_player) begin
                            errors++;
                            $display("FAIL mon_turn: got turn_done player=%0d expected is_move=%0d player=%0d",
                                     cur_player, e.is_move, e.player);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_players = 2'b00;
        pick_valid  = 1'b0;
        pick_match  = 1'b0;
        move_done   = 1'b0;
        win_in      = 1'b0;
        repeat (3) step();
        chk("rst_state", int'(state_o), 0);
        chk("rst_cur_player", int'(cur_player), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_move_req", int'(move_req), 0);
        chk("rst_turn_done", int'(turn_done), 0);
        rst_n = 1'b1;
        step();

        // Three players, three misses: 0 -> 1 -> 2 -> 0.
        num_players = 2'b01;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p3_state_wait", int'(state_o), 1);
        do_miss(2'd0, 2'd1);
        do_miss(2'd1, 2'd2);
        do_miss(2'd2, 2'd0);

        // Two players: match, move_done after 4 cycles, no win.
        abort = 1'b1;
        step();
        abort = 1'b0;
        num_players = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        expect_evt(1'b1, 2'd0);
        pick_valid = 1'b1;
        pick_match = 1'b1;
        step();
        pick_valid = 1'b0;
        pick_match = 1'b0;
        chk("p2_state_move", int'(state_o), 2);
        repeat (3) step();
        chk("p2_still_move", int'(state_o), 2);
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        chk("p2_state_check", int'(state_o), 3);
        step();
        chk("p2_back_wait", int'(state_o), 1);
        chk("p2_same_player", int'(cur_player), 0);

        // Timeout: turn_done 8 cycles after entering WAIT_PICK.
        expect_evt(1'b0, 2'd0);
        n = 20;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (turn_done === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("timeout_latency", n, 8);
        step();
        chk("timeout_next_player", int'(cur_player), 1);

        // Pick on the terminal cycle is a pick, not a timeout.
        expect_evt(1'b1, 2'd1);
        repeat (7) step();
        pick_valid = 1'b1;
        pick_match = 1'b1;
        step();
        pick_valid = 1'b0;
        pick_match = 1'b0;
        chk("term_pick_state", int'(state_o), 2);
        chk("term_pick_no_turn_done", int'(turn_done), 0);
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        step();
        chk("term_pick_player", int'(cur_player), 1);

        // Win as player 3 of 4.
        abort = 1'b1;
        step();
        abort = 1'b0;
        num_players = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        do_miss(2'd0, 2'd1);
        do_miss(2'd1, 2'd2);
        do_miss(2'd2, 2'd3);
        expect_evt(1'b1, 2'd3);
        pick_valid = 1'b1;
        pick_match = 1'b1;
        step();
        pick_valid = 1'b0;
        pick_match = 1'b0;
        move_done = 1'b1;
        step();
        move_done = 1'b0;
        win_in = 1'b1;
        step();
        win_in = 1'b0;
        chk("win_state", int'(state_o), 5);
        chk("win_game_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_state", int'(state_o), 1);
        chk("restart_player", int'(cur_player), 0);
        chk("restart_winner", int'(winner), 3);
        chk("restart_game_over", int'(game_over), 0);

        // Abort with the timer at 5, then picks without start do nothing.
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_state", int'(state_o), 0);
        chk("abort_player", int'(cur_player), 0);
        chk("abort_winner", int'(winner), 3);
        pick_valid = 1'b1;
        pick_match = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (move_req === 1'b1 || turn_done === 1'b1) n++;
            pick_match = ~pick_match;
        end
        pick_valid = 1'b0;
        pick_match = 1'b0;
        chk("idle_no_pulses", n, 0);
        chk("idle_state", int'(state_o), 0);

        // Async reset mid-MOVE.
        num_players = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        expect_evt(1'b1, 2'd0);
        pick_valid = 1'b1;
        pick_match = 1'b1;
        step();
        pick_valid = 1'b0;
        pick_match = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_player", int'(cur_player), 0);
        chk("async_rst_move_req", int'(move_req), 0);
        chk("async_rst_game_over", int'(game_over), 0);
        step();
        rst_n = 1'b1;
        step();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
Game-flow controller that sequences play among 2-4 players. It latches the player count at game start and owns the current-turn index. Each turn it waits for a tile pick, requests a move on a match, checks for a win, and passes the turn on a miss or timeout. It sits between the input/compare logic (pick, match) and the board/move datapath (move_req/move_done, win_in), and replaces ad-hoc turn toggling with one FSM.

Parameters:
TIMEOUT_CYCLES, 50_000_000, cycles allowed per pick before the turn is forfeited (1 s at 50 MHz).
TIMEOUT_W, 26, width of the turn timer (must hold TIMEOUT_CYCLES-1).

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  pulse; begins a game from IDLE or OVER.
abort  in  1  synchronous clear to IDLE from any state.
num_players  in  2  00=2, 01=3, 10=4, 11=4 (reserved, treated as 4); sampled only on an accepted start.
pick_valid  in  1  one-cycle strobe: the current player flipped a tile.
pick_match  in  1  qualifies pick_valid: 1 = tile matches the next board tile.
move_done  in  1  board datapath finished the requested move.
win_in  in  1  board reports the current player has won (valid in CHECK).
cur_player  out  2  index of the player whose turn it is.
move_req  out  1  one-cycle pulse requesting a one-step move for cur_player.
turn_done  out  1  one-cycle pulse when the turn passes.
game_over  out  1  high in OVER.
winner  out  2  player index latched on win.
state_o  out  3  FSM state encoding, for display/debug.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cur_player=0, winner=0, nplayers latch=2, timer=0. All pulse outputs=0 and game_over=0.
- States: IDLE(0), WAIT_PICK(1), MOVE(2), CHECK(3), NEXT(4), OVER(5). Remaining codes are unused and recover to IDLE.
- IDLE: on start, latch the player count, set cur_player=0, clear the timer, go to WAIT_PICK.
- WAIT_PICK: the timer increments each cycle.
  - pick_valid&pick_match: assert move_req on the transition cycle (registered, visible the next cycle for exactly 1 cycle); go to MOVE.
  - pick_valid&!pick_match: go to NEXT.
  - timer==TIMEOUT_CYCLES-1 with no pick: go to NEXT.
  - pick_valid in the same cycle as timer terminal: the pick takes priority.
- MOVE: wait for move_done; the timer is frozen. A pick_valid here is ignored. move_done is expected 1+ cycles after move_req; a move_done already high in the move_req cycle counts.
- CHECK (1 cycle): win_in=1 latches winner=cur_player and goes to OVER. Otherwise go back to WAIT_PICK with the timer cleared, and the same player continues.
- NEXT (1 cycle):
  - cur_player = (cur_player==nplayers-1) ? 0 : cur_player+1.
  - turn_done pulses 1 cycle.
  - Timer cleared; go to WAIT_PICK.
- OVER: game_over=1 and winner holds. start restarts as from IDLE; winner is retained until the next win.
- abort (sync) beats every other input. It forces IDLE, cur_player=0, clears pulses and timer, and keeps winner.
- start outside IDLE/OVER is ignored. pick_valid outside WAIT_PICK is ignored.
- Reset asserted mid-turn: immediate return to reset values; any move_req in flight is dropped.
- Width: the timer is TIMEOUT_W bits and saturates. It is compared for equality only.

Decomposition:
- Package tsched_pkg holds:
  - state localparams (3-bit codes above);
  - player-count encodings;
  - a function nplayers_decode(2-bit) returning 2..4.
- One sub-module, turn_timer: clear, enable, terminal-count output, parameterised by TIMEOUT_CYCLES and TIMEOUT_W.
- FSM and turn register live in turn_scheduler.

Test Plan:
- Reset: rst_n low mid-MOVE → state_o=0, cur_player=0, move_req=0, game_over=0 immediately (async).
- 3 players (num_players=01), start, then three picks with pick_match=0 → cur_player goes 0→1→2→0; turn_done pulses 3 times, each 1 cycle wide.
- 2 players: pick with match=1 → move_req 1 cycle; move_done after 4 cycles with win_in=0 → back in WAIT_PICK, cur_player unchanged=0.
- Timeout with TIMEOUT_CYCLES=8: no pick → turn_done exactly 8 cycles after entering WAIT_PICK, cur_player +1. Pick arriving on the terminal cycle → treated as a pick, not a timeout.
- Win: 4 players, cur_player=3, match, move_done, win_in=1 in CHECK → game_over=1, winner=3. start → WAIT_PICK, cur_player=0, winner still 3.
- abort during WAIT_PICK with timer=5 → IDLE next cycle. pick_valid and start-less stimulus then produce no move_req or turn_done.
